// File: rtl/demux_1to4_stream_pkg.sv
// Shared channel-count, select type and level-width helper for the 1-to-4 stream demux.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  // Occupancy needs one more bit than the pointers so that "full" is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_1to4_stream_chan_fifo.sv
// Per-channel FIFO: registered head (written word visible the cycle after push, no bypass).
// Push is ignored when full and pop when empty, so callers may present raw requests.
module chan_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  // Storage is reset too, so the head reads as zero while the channel is in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demux: one input stream steered by in_sel into four independent FIFOs.
// in_ready depends only on in_sel and registered occupancy; a full channel stalls only its own pushes.
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_W-1:0]                in_data,
  input  ch_sel_t                          in_sel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_CH*DATA_W-1:0]         out_data,
  output logic [NUM_CH-1:0]                out_valid,
  input  logic [NUM_CH-1:0]                out_ready,
  output logic [NUM_CH*lvl_w(DEPTH)-1:0]   ch_level
);

  localparam int LVL_W = lvl_w(DEPTH);

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;

  assign in_ready = ~full[in_sel];

  always_comb begin
    push         = '0;
    push[in_sel] = in_valid & in_ready;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push[k]),
      .pop     (out_ready[k]),
      .data_in (in_data),
      .head    (out_data[k*DATA_W +: DATA_W]),
      .full    (full[k]),
      .empty   (empty[k]),
      .level   (ch_level[k*LVL_W +: LVL_W])
    );
  end

  assign out_valid = ~empty;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed bench for demux_1to4_stream: per-channel queue model checked every cycle plus literal spot checks.
module tb_demux_1to4_stream;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   in_data = '0;
  logic [1:0]          in_sel = 2'd0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready = 4'b0000;
  logic [4*LW-1:0]     ch_level;

  int n_vec = 0;
  int n_err = 0;
  int maxlvl0 = 0;

  logic [DATA_W-1:0] mq[4][$];
  logic [DATA_W-1:0] dq[4][$];

  demux_1to4_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_level  (ch_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [1:0] s, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Model: a queue per channel; a push is refused when that queue already holds DEPTH words.
  always @(posedge clk or negedge rst_n) begin : mdl
    int  s;
    bit  acc;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
    end else begin
      s   = int'(in_sel);
      acc = in_valid && (mq[s].size() < DEPTH);
      for (int k = 0; k < 4; k++) begin
        if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      end
      if (acc) mq[s].push_back(in_data);
    end
  end

  // Record what the DUT actually hands to each consumer.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) dq[k].push_back(out_data[k*DATA_W +: DATA_W]);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq[in_sel].size() < DEPTH});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("level%0d", k), 32'(ch_level[k*LW +: LW]), 32'(mq[k].size()));
      chk($sformatf("valid%0d", k), {31'd0, out_valid[k]}, {31'd0, mq[k].size() != 0});
      if (mq[k].size() != 0)
        chk($sformatf("data%0d", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(mq[k][0]));
    end
    if (int'(ch_level[LW-1:0]) > maxlvl0) maxlvl0 = int'(ch_level[LW-1:0]);
  end

  initial begin : stim
    int cnt;
    bit got;

    // Reset state.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_level", {24'd0, ch_level}, 32'd0);
    in_sel = 2'd0;
    step();
    rst_n = 1'b1;
    step();

    // Routing: each word lands only on its own channel, one cycle after acceptance.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push1(2'(i), 8'(8'h10 + i));
      chk("route_valid", {28'd0, out_valid}, 32'(4'b0001 << i));
      chk("route_data", 32'(out_data[i*DATA_W +: DATA_W]), 32'(8'h10 + i));
    end
    step();
    chk("route_drained", {28'd0, out_valid}, 32'd0);

    // Backpressure on ch1.
    for (int k = 0; k < 4; k++) dq[k].delete();
    out_ready = 4'b1101;
    push1(2'd1, 8'h21);
    push1(2'd1, 8'h22);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h23;
    #1 chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_level1", 32'(ch_level[LW +: LW]), 32'd2);
    step();
    in_valid = 1'b0;
    step();
    push1(2'd0, 8'h05);
    out_ready = 4'b1111;
    step();
    chk("bp_head_after_pop", 32'(out_data[DATA_W +: DATA_W]), 32'h22);
    step();
    chk("bp_drain_count", 32'(dq[1].size()), 32'd2);
    if (dq[1].size() == 2) begin
      chk("bp_drain0", 32'(dq[1][0]), 32'h21);
      chk("bp_drain1", 32'(dq[1][1]), 32'h22);
    end
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h23;
    #1 chk("bp_in_ready_free", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    step();

    // Full channel with a same-cycle pop: push refused, pop completes.
    out_ready = 4'b0111;
    push1(2'd3, 8'h31);
    push1(2'd3, 8'h32);
    chk("full_level3", 32'(ch_level[3*LW +: LW]), 32'd2);
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h33;
    #1 chk("full_refused", {31'd0, in_ready}, 32'd0);
    step();
    chk("full_level_after_pop", 32'(ch_level[3*LW +: LW]), 32'd1);
    chk("full_ready_again", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("full_push_pop_level", 32'(ch_level[3*LW +: LW]), 32'd1);
    chk("full_new_head", 32'(out_data[3*DATA_W +: DATA_W]), 32'h33);
    step();

    // Wrap-around on ch0 with an irregular consumer.
    for (int k = 0; k < 4; k++) dq[k].delete();
    maxlvl0 = 0;
    for (int w = 0; w < 10; w++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(w);
      cnt = 0; got = 0;
      while (!got && cnt < 50) begin
        out_ready = {3'b111, 1'($urandom_range(0, 1))};
        #3;
        got = in_ready;
        step();
        cnt++;
      end
      if (!got) chk("wrap_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    repeat (4) step();
    chk("wrap_count", 32'(dq[0].size()), 32'd10);
    for (int i = 0; i < 10 && i < dq[0].size(); i++)
      chk($sformatf("wrap_word%0d", i), 32'(dq[0][i]), 32'(i));
    chk("wrap_max_level_ok", {31'd0, maxlvl0 <= 2}, 32'd1);

    // Concurrency: all channels pop while ch1 pushes at level 1.
    out_ready = 4'b0000;
    push1(2'd0, 8'h40);
    push1(2'd1, 8'h41);
    push1(2'd2, 8'h42);
    push1(2'd3, 8'h43);
    out_ready = 4'b1111;
    push1(2'd1, 8'h44);
    chk("conc_levels", {24'd0, ch_level}, 32'h0000_0004);
    chk("conc_valid", {28'd0, out_valid}, 32'h2);
    chk("conc_ch1_head", 32'(out_data[DATA_W +: DATA_W]), 32'h44);
    step();

    // Reset mid-stream with buffered words.
    out_ready = 4'b0000;
    push1(2'd0, 8'h51);
    push1(2'd2, 8'h52);
    push1(2'd2, 8'h53);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {28'd0, out_valid}, 32'd0);
    chk("mrst_level", {24'd0, ch_level}, 32'd0);
    in_sel = 2'd2;
    #1 chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    push1(2'd2, 8'hA5);
    chk("post_rst_valid", {28'd0, out_valid}, 32'h4);
    chk("post_rst_data", 32'(out_data[2*DATA_W +: DATA_W]), 32'hA5);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to4_stream.md
# demux_1to4_stream

Registered 1-to-4 stream demultiplexer: the receive-side counterpart of the team's 4-to-1 mux. A single valid/ready input stream carries data plus a 2-bit channel select (`{s1,s0}` ordering, `2'b00` → channel 0 … `2'b11` → channel 3). Each accepted word is steered into a per-channel FIFO. Each channel is drained independently over its own valid/ready port, so backpressure on one channel never drops data and never reorders data within a channel.

## Interface
- `DATA_W`, 8, data width of input and each output channel
- `DEPTH`, 2, entries per channel FIFO; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_data`  in  DATA_W  input word
- `in_sel`  in  2  destination channel, `{s1,s0}`
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  input accepted this cycle if `in_valid & in_ready`
- `out_data`  out  4*DATA_W  channel k on bits `[k*DATA_W +: DATA_W]`
- `out_valid`  out  4  bit k: channel k head word valid
- `out_ready`  in  4  bit k: channel k consumer ready
- `ch_level`  out  4*($clog2(DEPTH)+1)  occupancy of each channel FIFO

## Operation
- Push: `in_valid & in_ready` writes `in_data` into FIFO[`in_sel`].
- `in_ready = ~full[in_sel]`. It is combinational from `in_sel` and registered occupancy only. It has no path from `out_ready`.
- The sender holds `in_data` and `in_sel` stable while `in_valid=1 & in_ready=0`. The sender may not retarget `in_sel` while stalled.
- Pop: `out_valid[k] & out_ready[k]` advances FIFO k.
- `out_valid[k] = ~empty[k]`. `out_data` slice k is the FIFO k head, driven from registers.
- All four channels pop independently and may all pop in the same cycle as a push.
- Within a channel, order is strict FIFO. Across channels there is no ordering relation.
- Full channel, push and pop on that channel in the same cycle: the push is refused (`in_ready=0`). There is no same-cycle credit. The pop completes.
- Non-full, non-empty channel, push and pop in the same cycle: both complete and the level is unchanged.
- Empty channel, push: no bypass. The word becomes visible on the next cycle.
- Pointer arithmetic: `$clog2(DEPTH)`-bit read/write pointers wrap modulo DEPTH. The level counter is `$clog2(DEPTH)+1` bits and saturates structurally at DEPTH. Full is `level==DEPTH`; empty is `level==0`.
- `out_ready[k]` asserted while `out_valid[k]=0` has no effect.

## Timing
- Latency: a word accepted at edge N is presented on `out_valid[k]`/`out_data` after edge N. It is visible in cycle N+1.
- Throughput: one push per cycle, plus one pop per channel per cycle.
- Reset (`rst_n=0`, asynchronous):
  - All pointers and levels go to 0 immediately.
  - `out_valid=4'b0000`, `out_data` all zeros, `ch_level` all zeros.
  - `in_ready=1` for every `in_sel`.
- Reset mid-operation discards all buffered words. After release, the first edge with `rst_n=1` may accept a push.
- Reset deassertion is synchronised externally. The block does not resynchronise `rst_n`.

## Structure
- Package `demux_pkg`:
  - `NUM_CH=4` and `SEL_W=2`.
  - Typedef `ch_sel_t` (logic [1:0]).
  - Localparam helper for level width.
- Sub-module `chan_fifo`:
  - Parameters `DATA_W`, `DEPTH`.
  - Ports: push/pop, `data_in`, head, full, empty, level.
  - Instantiated 4× by a generate loop.
- The top level contains only the select decode, the `in_ready` mux and the output packing.

## Test plan
- Reset: `rst_n=0` mid-stream with channels holding data → `out_valid=0000`, all levels 0, `in_ready=1`. After release, push `0xA5` to ch2 → `out_valid=0100` and ch2 data `0xA5` one cycle later.
- Routing: `out_ready=1111`, push `0x10,0x11,0x12,0x13` with sel `0,1,2,3` on consecutive cycles → each appears only on its own channel, one cycle after acceptance, and no other `out_valid` bit toggles.
- Backpressure/full: `out_ready[1]=0`, push `0x21,0x22,0x23` to ch1 (DEPTH=2) → first two accepted, `in_ready=0` on the third, `ch_level[1]=2`. Switch to sel 0 after `in_valid` drops → accepted. Release `out_ready[1]` → `0x21`, `0x22` drained in order, then `0x23` accepted.
- Full + simultaneous pop: ch3 full, `out_ready[3]=1` and push to ch3 in the same cycle → push refused, pop completes, level 2→1. Next cycle the push is accepted.
- Wrap-around: ch0 with alternating push/pop for 10 words `0x00..0x09` at random `out_ready` → output sequence is exact, pointers wrap, level never exceeds 2.
- Concurrency: all four channels popping while a push lands on ch1 at `level=1` → ch1 level stays 1, the other channels decrement, no data loss.
